sysmgr_mem_initiator: RTL and testbench

- Initiator (master) end of the memory-stream request/response interface used by the system-manager register slave.
- Serialises single-word read/write commands from a local command port onto mem_req/mem_gnt/mem_rvalid.
- Contains a built-in "processor release" sequence: a password-qualified write to the control register, then a read-back check.
- Used by boot/debug logic to drive system-manager registers without going through AXI.

---
 rtl/sysmgr_mem_initiator.sv | 140 ++++++++++++++
 tb/tb_sysmgr_mem_initiator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysmgr_mem_initiator.sv
// Single-outstanding memory-stream initiator for system-manager registers.
// Serves a local command port and a built-in password-qualified processor release sequence.
module sysmgr_mem_initiator #(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           TIMEOUT    = 16,
    parameter logic [23:0]           PASSWORD   = 24'h1A2B3C,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR  = 8'h00
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    input  logic                    rel_start_i,
    input  logic                    rel_value_i,
    output logic                    rel_busy_o,
    output logic                    rel_done_o,
    output logic                    rel_ok_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_strb_o,
    output logic                    mem_we_o,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
    localparam int unsigned   CW      = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, REQ, WAIT, RSP, R_WR, R_WWAIT, R_RD, R_RWAIT, R_DONE
    } state_e;

    typedef struct packed {
        logic                    we;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] strb;
    } mem_req_t;

    state_e          state_q, state_d;
    mem_req_t        req_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic            err_q, rel_val_q, rel_ok_q;
    logic            in_req, in_wait, tmo;

    assign in_req  = (state_q == REQ)  || (state_q == R_WR)    || (state_q == R_RD);
    assign in_wait = (state_q == WAIT) || (state_q == R_WWAIT) || (state_q == R_RWAIT);
    assign tmo     = (in_req || in_wait) && (cnt_q == TO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Awaited event wins over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (rel_start_i) state_d = R_WR;
                     else if (cmd_valid_i) state_d = REQ;
            REQ:     if (mem_gnt_i) state_d = WAIT;    else if (tmo) state_d = RSP;
            WAIT:    if (mem_rvalid_i || tmo) state_d = RSP;
            RSP:     state_d = IDLE;
            R_WR:    if (mem_gnt_i) state_d = R_WWAIT; else if (tmo) state_d = R_DONE;
            R_WWAIT: if (mem_rvalid_i) state_d = R_RD; else if (tmo) state_d = R_DONE;
            R_RD:    if (mem_gnt_i) state_d = R_RWAIT; else if (tmo) state_d = R_DONE;
            R_RWAIT: if (mem_rvalid_i || tmo) state_d = R_DONE;
            R_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = '0;
        if ((state_d == state_q) && (in_req || in_wait)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rel_val_q <= 1'b0;
            rel_ok_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rel_start_i) begin
                        req_q     <= '{we: 1'b1, addr: CTRL_ADDR, strb: '1,
                                       wdata: DATA_WIDTH'({PASSWORD, 7'd0, rel_value_i})};
                        rel_val_q <= rel_value_i;
                        rel_ok_q  <= 1'b0;
                    end else if (cmd_valid_i) begin
                        req_q <= '{we: cmd_we_i, addr: cmd_addr_i, strb: cmd_strb_i,
                                   wdata: cmd_wdata_i};
                        err_q <= 1'b0;
                    end
                end
                REQ:     if (!mem_gnt_i && tmo) err_q <= 1'b1;
                WAIT: begin
                    if (mem_rvalid_i) rdata_q <= mem_rdata_i;
                    else if (tmo)     err_q   <= 1'b1;
                end
                R_WWAIT: if (mem_rvalid_i) req_q.we <= 1'b0;
                default: ;
            endcase
            // Only a read-back that arrives in time and matches can make the sequence succeed.
            if ((state_d == R_DONE) && (state_q != R_DONE))
                rel_ok_q <= (state_q == R_RWAIT) && mem_rvalid_i && (mem_rdata_i[0] == rel_val_q);
        end
    end

    always_comb begin
        cmd_ready_o = (state_q == IDLE) && !rel_start_i && !rst_i;
        mem_req_o   = in_req;
        mem_we_o    = req_q.we;
        mem_addr_o  = req_q.addr;
        mem_wdata_o = req_q.wdata;
        mem_strb_o  = req_q.strb;
        rsp_valid_o = (state_q == RSP);
        rsp_err_o   = (state_q == RSP) && err_q;
        rsp_rdata_o = rdata_q;
        rel_busy_o  = (state_q == R_WR) || (state_q == R_WWAIT) || (state_q == R_RD) ||
                      (state_q == R_RWAIT) || (state_q == R_DONE);
        rel_done_o  = (state_q == R_DONE);
        rel_ok_o    = rel_ok_q;
    end
endmodule

// File: tb/tb_sysmgr_mem_initiator.sv
// Directed bench for sysmgr_mem_initiator: command path, release sequence, timeout, reset.
module tb_sysmgr_mem_initiator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, cmd_ready, cmd_we;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        rel_start, rel_value, rel_busy, rel_done, rel_ok;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_strb;
    logic [83:0] outs;

    int total = 0;
    int bad   = 0;

    assign outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, rel_busy, rel_done, rel_ok,
                   mem_req, mem_addr, mem_wdata, mem_strb, mem_we};

    sysmgr_mem_initiator dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .rel_start_i(rel_start), .rel_value_i(rel_value), .rel_busy_o(rel_busy),
        .rel_done_o(rel_done), .rel_ok_o(rel_ok),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_we_o(mem_we),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step; step;
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outs got=%h exp=0", outs); end
        rst = 1'b0;
        step;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h00;
        cmd_wdata = 32'h1A2B3C01; cmd_strb = 4'hF;
        step;
        cmd_valid = 1'b0;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_strb} !== {2'b11, 8'h00, 32'h1A2B3C01, 4'hF}) begin
            bad++; $display("FAIL wr_req got=%b/%b/%h/%h/%h exp=1/1/00/1a2b3c01/f",
                            mem_req, mem_we, mem_addr, mem_wdata, mem_strb);
        end
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A50001;
        total++;
        if ({mem_req, rsp_valid} !== 2'b00) begin bad++; $display("FAIL wr_wait got=%b%b exp=00", mem_req, rsp_valid); end
        step;
        mem_rvalid = 1'b0;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hA5A50001}) begin
            bad++; $display("FAIL wr_rsp got=%b/%b/%h exp=1/0/a5a50001", rsp_valid, rsp_err, rsp_rdata);
        end
        step;
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL wr_idle got=%b%b exp=01", rsp_valid, cmd_ready); end
    endtask

    task automatic test_read_delayed;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h00; cmd_strb = 4'hF;
        step;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h00}) begin
                bad++; $display("FAIL rd_req%0d got=%b/%b/%h exp=1/0/00", i, mem_req, mem_we, mem_addr);
            end
            mem_gnt = (i == 3);
            step;
        end
        mem_gnt = 1'b0;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL rd_drop got=%b exp=0", mem_req); end
        mem_rvalid = 1'b1; mem_rdata = 32'h00000001;
        step;
        mem_rvalid = 1'b0;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1}) begin
            bad++; $display("FAIL rd_rsp got=%b/%b/%h exp=1/0/00000001", rsp_valid, rsp_err, rsp_rdata);
        end
        step;
    endtask

    // Slave model: grants immediately, answers next cycle; accepts writes only with its key.
    task automatic run_release(input logic val, input logic bad_pw, input logic exp_ok, input string tag);
        logic [23:0] key;
        logic slv, pend, done;
        int n_tr;
        key = bad_pw ? 24'h555555 : 24'h1A2B3C;
        slv = 1'b0; pend = 1'b0; done = 1'b0; n_tr = 0;
        rel_start = 1'b1; rel_value = val;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL %s start_ready got=%b exp=0", tag, cmd_ready); end
        step;
        rel_start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            total++;
            if ({rel_busy, cmd_ready} !== 2'b10) begin
                bad++; $display("FAIL %s busy%0d got=%b%b exp=10", tag, i, rel_busy, cmd_ready);
            end
            mem_rvalid = pend;
            mem_rdata  = {31'd0, slv};
            if (mem_req) begin
                n_tr++;
                total++;
                if (n_tr == 1 && {mem_we, mem_addr, mem_wdata, mem_strb} !== {1'b1, 8'h00, 24'h1A2B3C, 7'd0, val, 4'hF}) begin
                    bad++; $display("FAIL %s wr got=%b/%h/%h/%h", tag, mem_we, mem_addr, mem_wdata, mem_strb);
                end else if (n_tr == 2 && {mem_we, mem_addr, mem_strb} !== {1'b0, 8'h00, 4'hF}) begin
                    bad++; $display("FAIL %s rd got=%b/%h/%h exp=0/00/f", tag, mem_we, mem_addr, mem_strb);
                end
                if (mem_we && mem_wdata[31:8] == key) slv = mem_wdata[0];
            end
            mem_gnt = mem_req;
            pend    = mem_req;
            if (rel_done) begin
                done = 1'b1;
                total++;
                if (rel_ok !== exp_ok) begin bad++; $display("FAIL %s ok got=%b exp=%b", tag, rel_ok, exp_ok); end
            end
            step;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL %s no_done got=0 exp=1", tag); end
        total++;
        if (n_tr !== 2) begin bad++; $display("FAIL %s ntr got=%0d exp=2", tag, n_tr); end
        total++;
        if ({rel_busy, rel_done, rel_ok} !== {2'b00, exp_ok}) begin
            bad++; $display("FAIL %s hold got=%b%b%b exp=00%b", tag, rel_busy, rel_done, rel_ok, exp_ok);
        end
    endtask

    task automatic test_release;
        run_release(1'b1, 1'b0, 1'b1, "rel_good1");
        run_release(1'b0, 1'b0, 1'b1, "rel_good0");
        run_release(1'b1, 1'b1, 1'b0, "rel_badpw");
    endtask

    task automatic test_priority;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h10; cmd_strb = 4'h3;
        run_release(1'b1, 1'b0, 1'b1, "prio_rel");
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL prio_ready got=%b exp=1", cmd_ready); end
        step;
        cmd_valid = 1'b0;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_strb} !== {2'b10, 8'h10, 4'h3}) begin
            bad++; $display("FAIL prio_req got=%b/%b/%h/%h exp=1/0/10/3", mem_req, mem_we, mem_addr, mem_strb);
        end
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0010;
        step;
        mem_rvalid = 1'b0;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hCAFE0010}) begin
            bad++; $display("FAIL prio_rsp got=%b/%b/%h exp=1/0/cafe0010", rsp_valid, rsp_err, rsp_rdata);
        end
        step;
    endtask

    task automatic test_timeout;
        int n;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h04;
        step;
        cmd_valid = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin n++; step; end
        total++;
        if (n !== 16) begin bad++; $display("FAIL to_cycles got=%0d exp=16", n); end
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'hCAFE0010}) begin
            bad++; $display("FAIL to_rsp got=%b/%b/%h exp=1/1/cafe0010", rsp_valid, rsp_err, rsp_rdata);
        end
        step;
        total++;
        if ({cmd_ready, rsp_valid, rsp_err} !== 3'b100) begin
            bad++; $display("FAIL to_idle got=%b%b%b exp=100", cmd_ready, rsp_valid, rsp_err);
        end
    endtask

    task automatic test_reset_mid;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h08;
        step;
        cmd_valid = 1'b0; mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        step;
        rst = 1'b0; mem_rvalid = 1'b0;
        total++;
        if (outs !== '0) begin bad++; $display("FAIL rstmid_outs got=%h exp=0", outs); end
        step;
        total++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL rstmid_idle got=%b%b exp=10", cmd_ready, rsp_valid); end
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            step;
            total++;
            if ({rsp_valid, mem_req, cmd_ready, rsp_rdata} !== {3'b001, 32'h0}) begin
                bad++; $display("FAIL stray%0d got=%b%b%b/%h exp=001/00000000", i, rsp_valid, mem_req, cmd_ready, rsp_rdata);
            end
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        rel_start = 1'b0; rel_value = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset;
        test_write;
        test_read_delayed;
        test_release;
        test_priority;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
